// File: rtl/exu_alu_add_arb_if.sv
// Add/sub request and response channel between one EXU sub-unit and the shared adder arbiter.
// The requester uses the master modport, the arbiter uses the slave modport.
interface exu_alu_add_arb_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_op1;
  logic [XLEN-1:0] req_op2;
  logic            req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_res;

  modport master (
    output req_valid, req_op1, req_op2, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_res
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_res
  );
endinterface

// File: rtl/exu_alu_add_arb.sv
// Arbiter for the EXU's shared XLEN adder serving BJP, ALU and AGU with a one-deep result register.
// Define EXU_ADD_ARB_RR_EN for round-robin priority; otherwise fixed priority bjp > alu > agu.
module exu_alu_add_arb #(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  exu_alu_add_arb_if.slave         bjp,
  exu_alu_add_arb_if.slave         alu,
  exu_alu_add_arb_if.slave         agu,
  input  logic                     agu_req_lock
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam logic [1:0] ID_BJP = 2'd0;
  localparam logic [1:0] ID_ALU = 2'd1;
  localparam logic [1:0] ID_AGU = 2'd2;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            lock_q, lock_d;
  logic [2:0]      rsp_valid_q, rsp_valid_d;

  logic [2:0]      req_valid;
  logic [2:0]      rsp_ready;
  logic [2:0]      eligible;
  logic [2:0]      grant;
  logic [2:0]      req_ready;
  logic [1:0]      grant_id;
  logic            drain;
  logic            can_accept;
  logic            accept;
  logic [XLEN-1:0] sel_op1;
  logic [XLEN-1:0] sel_op2;
  logic            sel_sub;
  logic [XLEN-1:0] sum;

  assign req_valid = {agu.req_valid, alu.req_valid, bjp.req_valid};
  assign rsp_ready = {agu.rsp_ready, alu.rsp_ready, bjp.rsp_ready};

  // A pending lock reserves the adder for AGU's second access.
  assign eligible = lock_q ? (req_valid & 3'b100) : req_valid;

`ifdef EXU_ADD_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    grant = 3'b000;
    unique case (ptr_q)
      ID_ALU: begin
        if (eligible[1])      grant = 3'b010;
        else if (eligible[2]) grant = 3'b100;
        else if (eligible[0]) grant = 3'b001;
      end
      ID_AGU: begin
        if (eligible[2])      grant = 3'b100;
        else if (eligible[0]) grant = 3'b001;
        else if (eligible[1]) grant = 3'b010;
      end
      default: begin
        if (eligible[0])      grant = 3'b001;
        else if (eligible[1]) grant = 3'b010;
        else if (eligible[2]) grant = 3'b100;
      end
    endcase
  end
`else
  always_comb begin
    grant = 3'b000;
    if (eligible[0])      grant = 3'b001;
    else if (eligible[1]) grant = 3'b010;
    else if (eligible[2]) grant = 3'b100;
  end
`endif

  // The register may reload only when empty or when its owner drains it in the same cycle.
  assign drain      = (state_q == FULL) && rsp_ready[owner_q];
  assign can_accept = rst_n && ((state_q == IDLE) || drain);
  assign req_ready  = grant & {3{can_accept}};
  assign accept     = |req_ready;

  always_comb begin
    grant_id = ID_BJP;
    sel_op1  = bjp.req_op1;
    sel_op2  = bjp.req_op2;
    sel_sub  = bjp.req_sub;
    if (grant[1]) begin
      grant_id = ID_ALU;
      sel_op1  = alu.req_op1;
      sel_op2  = alu.req_op2;
      sel_sub  = alu.req_sub;
    end else if (grant[2]) begin
      grant_id = ID_AGU;
      sel_op1  = agu.req_op1;
      sel_op2  = agu.req_op2;
      sel_sub  = agu.req_sub;
    end
  end

  // Subtraction reuses the adder as op1 + ~op2 + 1; the carry out is dropped.
  assign sum = sel_op1 + (sel_sub ? ~sel_op2 : sel_op2) + {{(XLEN-1){1'b0}}, sel_sub};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    res_d       = res_q;
    lock_d      = lock_q;
    rsp_valid_d = rsp_valid_q;
`ifdef EXU_ADD_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    if (accept) begin
      state_d     = FULL;
      owner_d     = grant_id;
      res_d       = sum;
      rsp_valid_d = grant;
      if (grant[2]) begin
        lock_d = agu_req_lock;
      end
`ifdef EXU_ADD_ARB_RR_EN
      unique case (grant_id)
        ID_BJP:  ptr_d = ID_ALU;
        ID_ALU:  ptr_d = ID_AGU;
        default: ptr_d = ID_BJP;
      endcase
`endif
    end else if (drain) begin
      state_d     = IDLE;
      rsp_valid_d = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= ID_BJP;
      res_q       <= '0;
      lock_q      <= 1'b0;
      rsp_valid_q <= 3'b000;
`ifdef EXU_ADD_ARB_RR_EN
      ptr_q       <= ID_BJP;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      res_q       <= res_d;
      lock_q      <= lock_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef EXU_ADD_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bjp.req_ready = req_ready[0];
  assign alu.req_ready = req_ready[1];
  assign agu.req_ready = req_ready[2];

  assign bjp.rsp_valid = rsp_valid_q[0];
  assign alu.rsp_valid = rsp_valid_q[1];
  assign agu.rsp_valid = rsp_valid_q[2];

  assign bjp.rsp_res = res_q;
  assign alu.rsp_res = res_q;
  assign agu.rsp_res = res_q;

endmodule

// File: tb/tb_exu_alu_add_arb.sv
// Self-checking bench for exu_alu_add_arb: directed vectors, corner sequences and random traffic
// compared against a transaction-level model of the shared adder arbiter.
module tb_exu_alu_add_arb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]      tb_valid;
  logic [2:0]      tb_sub;
  logic [2:0]      tb_rsp_ready;
  logic [XLEN-1:0] tb_op1 [3];
  logic [XLEN-1:0] tb_op2 [3];
  logic            tb_lock;

  logic [2:0]      dut_req_ready;
  logic [2:0]      dut_rsp_valid;
  logic [XLEN-1:0] dut_res [3];

  exu_alu_add_arb_if #(.XLEN(XLEN)) bjp_if ();
  exu_alu_add_arb_if #(.XLEN(XLEN)) alu_if ();
  exu_alu_add_arb_if #(.XLEN(XLEN)) agu_if ();

  assign bjp_if.req_valid = tb_valid[0];
  assign alu_if.req_valid = tb_valid[1];
  assign agu_if.req_valid = tb_valid[2];
  assign bjp_if.req_op1   = tb_op1[0];
  assign alu_if.req_op1   = tb_op1[1];
  assign agu_if.req_op1   = tb_op1[2];
  assign bjp_if.req_op2   = tb_op2[0];
  assign alu_if.req_op2   = tb_op2[1];
  assign agu_if.req_op2   = tb_op2[2];
  assign bjp_if.req_sub   = tb_sub[0];
  assign alu_if.req_sub   = tb_sub[1];
  assign agu_if.req_sub   = tb_sub[2];
  assign bjp_if.rsp_ready = tb_rsp_ready[0];
  assign alu_if.rsp_ready = tb_rsp_ready[1];
  assign agu_if.rsp_ready = tb_rsp_ready[2];

  assign dut_req_ready = {agu_if.req_ready, alu_if.req_ready, bjp_if.req_ready};
  assign dut_rsp_valid = {agu_if.rsp_valid, alu_if.rsp_valid, bjp_if.rsp_valid};
  assign dut_res[0]    = bjp_if.rsp_res;
  assign dut_res[1]    = alu_if.rsp_res;
  assign dut_res[2]    = agu_if.rsp_res;

  exu_alu_add_arb #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bjp          (bjp_if.slave),
    .alu          (alu_if.slave),
    .agu          (agu_if.slave),
    .agu_req_lock (tb_lock)
  );

  // Transaction-level model: is a result held, who owns it, its value, lock and RR pointer.
  bit              m_full;
  int              m_owner;
  logic [XLEN-1:0] m_res;
  bit              m_lock;
  int              m_ptr;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] obs_ready;
  logic [2:0] last_acc;

  typedef struct {
    int              req;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            sub;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_owner = 0;
    m_res   = '0;
    m_lock  = 1'b0;
    m_ptr   = 0;
  endtask

  function automatic int pick_grant();
    for (int k = 0; k < 3; k++) begin
      int r;
`ifdef EXU_ADD_ARB_RR_EN
      r = (m_ptr + k) % 3;
`else
      r = k;
`endif
      if (tb_valid[r] && (!m_lock || r == 2)) return r;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    tb_valid     = 3'b000;
    tb_sub       = 3'b000;
    tb_rsp_ready = 3'b000;
    tb_lock      = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tb_op1[r] = '0;
      tb_op2[r] = '0;
    end
  endtask

  task automatic applyStimulus_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(string tag);
    int              g;
    bit              can;
    logic [2:0]      exp_ready;
    logic [2:0]      exp_rv;
    logic [63:0]     wide;
    @(negedge clk);
    g         = pick_grant();
    can       = !m_full || tb_rsp_ready[m_owner];
    exp_ready = 3'b000;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    exp_rv = 3'b000;
    if (m_full) exp_rv[m_owner] = 1'b1;
    obs_ready = dut_req_ready;
    check({tag, " req_ready"}, 32'(dut_req_ready), 32'(exp_ready));
    check({tag, " rsp_valid"}, 32'(dut_rsp_valid), 32'(exp_rv));
    for (int r = 0; r < 3; r++) begin
      check($sformatf("%s rsp_res[%0d]", tag, r), dut_res[r], m_res);
    end
    @(posedge clk);
    if (|exp_ready) begin
      if (tb_sub[g]) wide = {32'd0, tb_op1[g]} - {32'd0, tb_op2[g]};
      else           wide = {32'd0, tb_op1[g]} + {32'd0, tb_op2[g]};
      m_res   = wide[XLEN-1:0];
      m_owner = g;
      m_full  = 1'b1;
      if (g == 2) m_lock = tb_lock;
      m_ptr = (g + 1) % 3;
    end else if (m_full && tb_rsp_ready[m_owner]) begin
      m_full = 1'b0;
    end
    last_acc = exp_ready;
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] exp_vec;

    vecs[0] = '{0, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'h8000_0004};
    vecs[1] = '{1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE};
    vecs[2] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vecs[3] = '{2, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789};
    vecs[5] = '{2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF};
    vecs[6] = '{1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000};

    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    last_acc = 3'b000;
    #3;
    checkOutput("reset rsp_valid", 32'(dut_rsp_valid), 32'h0);
    checkOutput("reset req_ready", 32'(dut_req_ready), 32'h0);
    checkOutput("reset rsp_res", dut_res[0], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle");

    // Directed single-requester vectors
    tb_rsp_ready = 3'b111;
    for (int i = 0; i < 7; i++) begin
      exp_vec              = 3'b000;
      exp_vec[vecs[i].req] = 1'b1;
      tb_valid             = exp_vec;
      tb_op1[vecs[i].req]  = vecs[i].op1;
      tb_op2[vecs[i].req]  = vecs[i].op2;
      tb_sub[vecs[i].req]  = vecs[i].sub;
      step($sformatf("vec%0d accept", i));
      checkOutput($sformatf("vec%0d grant", i), 32'(obs_ready), 32'(exp_vec));
      tb_valid = 3'b000;
      checkOutput($sformatf("vec%0d result", i), dut_res[vecs[i].req], vecs[i].exp);
      checkOutput($sformatf("vec%0d owner", i), 32'(dut_rsp_valid), 32'(exp_vec));
      step($sformatf("vec%0d drain", i));
    end

    // All three requesting continuously with responses always consumed
    applyStimulus_reset();
    tb_rsp_ready = 3'b111;
    tb_valid     = 3'b111;
    for (int r = 0; r < 3; r++) begin
      tb_op1[r] = 32'(r * 16 + 1);
      tb_op2[r] = 32'(r + 7);
    end
    for (int i = 0; i < 6; i++) begin
      step($sformatf("all%0d", i));
`ifdef EXU_ADD_ARB_RR_EN
      exp_vec = 3'b001 << (i % 3);
`else
      exp_vec = 3'b001;
`endif
      checkOutput($sformatf("all%0d grant", i), 32'(obs_ready), 32'(exp_vec));
    end
    tb_valid = 3'b000;
    step("all drain");

    // Locked two-part AGU access
    applyStimulus_reset();
    tb_rsp_ready = 3'b111;
    tb_valid     = 3'b100;
    tb_lock      = 1'b1;
    tb_op1[2]    = 32'h0000_1000;
    tb_op2[2]    = 32'h0000_0010;
    step("lock first");
    checkOutput("lock first grant", 32'(obs_ready), 32'h4);
    tb_valid  = 3'b011;
    tb_lock   = 1'b0;
    tb_op1[0] = 32'h0000_0001;
    tb_op2[0] = 32'h0000_0002;
    tb_op1[1] = 32'h0000_0003;
    tb_op2[1] = 32'h0000_0004;
    step("lock hold0");
    checkOutput("lock hold0 grant", 32'(obs_ready), 32'h0);
    step("lock hold1");
    checkOutput("lock hold1 grant", 32'(obs_ready), 32'h0);
    tb_valid  = 3'b111;
    tb_op1[2] = 32'h0000_1004;
    step("lock second");
    checkOutput("lock second grant", 32'(obs_ready), 32'h4);
    tb_valid = 3'b011;
    step("lock released");
    checkOutput("lock released grant", 32'(obs_ready), 32'h1);
    tb_valid = 3'b000;
    step("lock drain");

    // Owner back-pressure for three cycles
    applyStimulus_reset();
    tb_rsp_ready = 3'b000;
    tb_valid     = 3'b001;
    tb_op1[0]    = 32'd10;
    tb_op2[0]    = 32'd20;
    step("bp accept");
    checkOutput("bp accept grant", 32'(obs_ready), 32'h1);
    tb_valid  = 3'b010;
    tb_op1[1] = 32'd100;
    tb_op2[1] = 32'd1;
    tb_sub[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp hold%0d", i));
      checkOutput($sformatf("bp hold%0d grant", i), 32'(obs_ready), 32'h0);
      checkOutput($sformatf("bp hold%0d res", i), dut_res[0], 32'd30);
      checkOutput($sformatf("bp hold%0d owner", i), 32'(dut_rsp_valid), 32'h1);
    end
    tb_rsp_ready = 3'b001;
    step("bp drain");
    checkOutput("bp drain grant", 32'(obs_ready), 32'h2);
    tb_valid     = 3'b000;
    tb_rsp_ready = 3'b111;
    checkOutput("bp next owner", 32'(dut_rsp_valid), 32'h2);
    checkOutput("bp next res", dut_res[1], 32'd99);
    step("bp final");

    // Reset while a locked AGU result is held
    applyStimulus_reset();
    tb_rsp_ready = 3'b000;
    tb_valid     = 3'b100;
    tb_lock      = 1'b1;
    tb_op1[2]    = 32'h0000_0040;
    tb_op2[2]    = 32'h0000_0004;
    step("rst full");
    tb_valid  = 3'b111;
    tb_op1[0] = 32'h0000_0011;
    tb_op2[0] = 32'h0000_0022;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst async rsp_valid", 32'(dut_rsp_valid), 32'h0);
    checkOutput("rst async req_ready", 32'(dut_req_ready), 32'h0);
    checkOutput("rst async res", dut_res[2], 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    tb_rsp_ready = 3'b111;
    step("rst first");
    checkOutput("rst first grant", 32'(obs_ready), 32'h1);
    tb_valid = 3'b000;
    step("rst drain");

    // Randomized traffic with requesters holding requests until accepted
    applyStimulus_reset();
    last_acc = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (last_acc[r]) tb_valid[r] = 1'b0;
        if (!tb_valid[r] && $urandom_range(0, 99) < 60) begin
          tb_valid[r] = 1'b1;
          tb_op1[r]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          tb_op2[r]   = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
          tb_sub[r]   = 1'($urandom_range(0, 1));
          if (r == 2) tb_lock = ($urandom_range(0, 3) == 0);
        end
      end
      tb_rsp_ready = 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
